regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

- Shares the single register-file write port between two write-back requesters:
  - the ALU result path;
  - the memory load-return path.
- Drives the regfile's `rw_sel`/`wd`/`we` from registered outputs.
- Keeps an 8-bit pending-write scoreboard so issue logic can stall on registers with an outstanding write.
- Sits between execute/memory stages and the 8×6-bit regfile in the c61 core.

## Interface
Parameters:
- `STARVE_LIMIT`, default 3: consecutive contested losses by ALU before it is forced to win (fixed-priority mode only); legal 1–3.

Ports:
- `clk`  in  1  core clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `alu_valid`  in  1  ALU write-back request
- `alu_rd`  in  3  ALU destination register
- `alu_data`  in  6  ALU write data
- `alu_ready`  out  1  ALU request accepted this cycle (combinational)
- `mem_valid`  in  1  load write-back request
- `mem_rd`  in  3  load destination register
- `mem_data`  in  6  load write data
- `mem_ready`  out  1  load request accepted this cycle (combinational)
- `iss_valid`  in  1  instruction issued that will write `iss_rd`
- `iss_rd`  in  3  destination of issued instruction
- `busy`  out  8  per-register pending-write flags (registered)
- `we`  out  1  regfile write enable (registered)
- `rw_sel`  out  3  regfile write select (registered)
- `wd`  out  6  regfile write data (registered)

## Operation
- Grant (combinational, from current valids and state):
  - Only one valid: that requester is granted.
  - Both valid: contested cycle; winner chosen by the arbitration mode.
  - Neither valid: no grant.
- `x_ready` = `x_valid` & granted(x). Never asserted without the matching valid.
- Fixed-priority mode (default): `mem` wins contested cycles. A 2-bit starvation counter tracks ALU losses:
  - increments on each contested cycle ALU loses;
  - when counter == `STARVE_LIMIT`, ALU wins the next contested cycle and the counter clears;
  - clears on any cycle ALU is accepted;
  - holds when there is no contention.
- Accepted request (`valid & ready`) in cycle N loads `we`=1 and the selected `rd`/`data` into the output register. With no acceptance, `we`=0 next cycle, and `rw_sel`/`wd` hold their last values.
- Scoreboard `busy[r]`:
  - Set at the edge ending a cycle with `iss_valid` & `iss_rd`==r.
  - Cleared at the edge ending a cycle with `we`=1 & `rw_sel`==r.
  - Set and clear of the same r in the same cycle: set wins.
  - Issue to an already-busy register: stays busy. WAW ordering is the issuer's responsibility; the first retiring write clears the bit.
- Both requesters targeting the same `rd` in the same cycle: handled normally; the loser writes in a later cycle.
- Reset values (async on `rst_n` low):
  - `we`=0, `rw_sel`=0, `wd`=0, `busy`=8'h00;
  - starvation counter 0, RR pointer = ALU-next.
  - `alu_ready`/`mem_ready` are forced to 0 while `rst_n` is low.
- Reset asserted mid-operation: a pending registered write is dropped (`we` forced 0) and all busy bits clear.

## Timing
- Cycle N: request accepted (`ready` high).
- Cycle N+1: `we`/`rw_sel`/`wd` valid at regfile; regfile writes at the edge ending N+1.
- Cycle N+2: new value readable on regfile read ports; `busy[rd]` low.
- `busy` therefore deasserts in the same cycle the data becomes visible. No read-after-write bypass is required of issue logic.
- Issue in cycle M: `busy[iss_rd]` high from M+1.
- Throughput: one write per cycle, sustained.
- Requesters may hold valid indefinitely; `data`/`rd` must stay stable while valid and not ready.

## Configuration
- Macro: `WB_ARB_RR_EN`.
- Undefined: fixed `mem` priority with ALU starvation counter, as above.
- Defined:
  - Contested cycles use round-robin arbitration, with no starvation counter and `STARVE_LIMIT` ignored.
  - A 1-bit last-winner pointer grants the requester that did not win the previous contested cycle.
  - The pointer updates only on contested cycles; after reset the ALU wins the first contested cycle.

## Test plan
- Reset: hold `rst_n`=0 with both valids high → `we`=0, `busy`=8'h00, both readies 0. Release → first contested grant matches mode (mem fixed; ALU under RR).
- Single write: `alu_valid`=1, `alu_rd`=5, `alu_data`=6'h2A in cycle N → `alu_ready`=1 in N; `we`=1, `rw_sel`=5, `wd`=6'h2A in N+1; `we`=0 in N+2.
- Contention, fixed mode, `STARVE_LIMIT`=3, both valid continuously:
  - grants are mem, mem, mem, ALU, mem…;
  - after reset, ALU's first grant comes on the 4th contested cycle, then every 4th cycle.
- Contention under `WB_ARB_RR_EN`, both valid continuously → grants alternate ALU, mem, ALU, mem; write-port `we` stays 1 every cycle.
- Scoreboard:
  - `iss_valid` with `iss_rd`=3 in cycle M → `busy`=8'h08 from M+1.
  - ALU write to r3 accepted in N → `busy[3]` clears in N+2.
  - Issue to r3 in cycle N+1 (same cycle `we` targets r3) → `busy[3]` stays 1.
- Reset mid-write: accept a mem write to r7 in N, assert `rst_n` low during N+1 → `we` drops immediately and `busy`=8'h00; no write reaches the regfile after reset.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: shares the regfile write port between ALU and load return,
// and keeps a pending-write scoreboard. Define WB_ARB_RR_EN for round-robin arbitration.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alu_valid,
  input  logic [2:0] alu_rd,
  input  logic [5:0] alu_data,
  output logic       alu_ready,
  input  logic       mem_valid,
  input  logic [2:0] mem_rd,
  input  logic [5:0] mem_data,
  output logic       mem_ready,
  input  logic       iss_valid,
  input  logic [2:0] iss_rd,
  output logic [7:0] busy,
  output logic       we,
  output logic [2:0] rw_sel,
  output logic [5:0] wd
);

  logic       contested;
  logic       alu_pick;
  logic       alu_grant;
  logic       mem_grant;
  logic [7:0] set_mask;
  logic [7:0] clr_mask;

  assign contested = alu_valid & mem_valid;

`ifdef WB_ARB_RR_EN
  // Pointer names the requester due to win the next contested cycle.
  logic alu_next;

  assign alu_pick = alu_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         alu_next <= 1'b1;
    else if (contested) alu_next <= ~alu_pick;
  end
`else
  logic [1:0] starve_cnt;

  assign alu_pick = (starve_cnt == 2'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         starve_cnt <= '0;
    else if (alu_grant) starve_cnt <= '0;
    else if (contested) starve_cnt <= starve_cnt + 2'd1;
  end
`endif

  assign alu_grant = rst_n & alu_valid & (contested ? alu_pick : 1'b1);
  assign mem_grant = rst_n & mem_valid & ~alu_grant;
  assign alu_ready = alu_grant;
  assign mem_ready = mem_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we     <= 1'b0;
      rw_sel <= '0;
      wd     <= '0;
    end else begin
      we <= alu_grant | mem_grant;
      if (alu_grant) begin
        rw_sel <= alu_rd;
        wd     <= alu_data;
      end else if (mem_grant) begin
        rw_sel <= mem_rd;
        wd     <= mem_data;
      end
    end
  end

  // Set is ORed in after the clear so a same-cycle issue keeps the bit high.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_valid) set_mask[iss_rd] = 1'b1;
    if (we)        clr_mask[rw_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= (busy & ~clr_mask) | set_mask;
  end

endmodule
